burst_memory: RTL and testbench

Parametrised synchronous data/program memory for the multi-cycle accumulator CPU. It is the successor of the flat byte memory. Reads and writes are now clocked through a req/ready handshake, with bursts of 1..MAX_BEATS consecutive words so a multi-byte instruction can be fetched in one transaction. A side-band loader port lets the testbench or boot logic preload program and data images, replacing hard-coded contents.

---
 rtl/burst_memory.sv | 159 +++++++++++++++
 tb/tb_burst_memory.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_memory.sv
// burst_memory: synchronous word memory with a req/ready burst port and a
// side-band loader port.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high reset (control state only; memory kept)
//   req        transaction request, accepted when ready=1
//   we         1 = write burst, 0 = read burst (sampled with req)
//   addr       burst start address (sampled with req)
//   beats      burst length minus 1 (sampled with req)
//   wdata      write data, one word per beat
//   ready      idle, able to accept a request or a load
//   rvalid     rdata holds a read beat this cycle
//   rdata      registered read data
//   load_en    loader write strobe
//   load_addr  loader address
//   load_data  loader data
//   load_err   one-cycle pulse: a load strobe was dropped
module burst_memory #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 13,
    parameter int DEPTH     = 8192,
    parameter int MAX_BEATS = 4,
    parameter int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BEAT_W-1:0] beats,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   ptr;
    logic [BEAT_W:0]     cnt;     // one extra bit: reads count beats+1 down to 0
    logic [BEAT_W-1:0]   beats_c;
    logic                accept;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (ADDR_W+1)'(a) < (ADDR_W+1)'(DEPTH);
    endfunction

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(DEPTH - 1))
            return '0;
        return a + 1'b1;
    endfunction

    function automatic logic [BEAT_W-1:0] clamp_beats(input logic [BEAT_W-1:0] b);
        if (int'(b) > MAX_BEATS - 1)
            return BEAT_W'(MAX_BEATS - 1);
        return b;
    endfunction

    assign beats_c = clamp_beats(beats);
    assign accept  = req && ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!we)
                        state_next = READ;
                    else if (beats_c != '0)
                        state_next = WRITE;
                end
            end
            // READ issues while cnt != 0, then spends one cycle dropping rvalid
            READ:    if (cnt == '0) state_next = IDLE;
            WRITE:   if (cnt == (BEAT_W+1)'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single write port shared by write beat 0, later write beats and the loader
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = wdata;
        if (state == IDLE && accept && we) begin
            mem_we    = 1'b1;
            mem_waddr = addr;
        end else if (state == WRITE) begin
            mem_we    = 1'b1;
        end else if (load_en && ready && !req) begin
            mem_we    = 1'b1;
            mem_waddr = load_addr;
            mem_wdata = load_data;
        end
        if (reset || !in_range(mem_waddr))
            mem_we = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ready    <= 1'b1;
            rvalid   <= 1'b0;
            rdata    <= '0;
            load_err <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            ready    <= (state_next == IDLE);
            load_err <= load_en && (!ready || req);
            rvalid   <= (state == READ) && (cnt != '0);
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (we) begin
                            ptr <= next_ptr(addr);
                            cnt <= (BEAT_W+1)'(beats_c);
                        end else begin
                            ptr <= addr;
                            cnt <= (BEAT_W+1)'(beats_c) + 1'b1;
                        end
                    end
                end
                READ: begin
                    if (cnt != '0) begin
                        rdata <= in_range(ptr) ? mem[ptr[IDX_W-1:0]] : '0;
                        ptr   <= next_ptr(ptr);
                        cnt   <= cnt - 1'b1;
                    end
                end
                WRITE: begin
                    ptr <= next_ptr(ptr);
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_memory.sv
// Testbench for burst_memory: directed bursts and loader traffic, read data
// checked through an expected-value queue drained by a monitor process.
module tb_burst_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [12:0] addr;
    logic [1:0]  beats;
    logic [7:0]  wdata;
    logic        ready;
    logic        rvalid;
    logic [7:0]  rdata;
    logic        load_en;
    logic [12:0] load_addr;
    logic [7:0]  load_data;
    logic        load_err;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    burst_memory dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .beats    (beats),
        .wdata    (wdata),
        .ready    (ready),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .load_err (load_err)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented read beat must match the oldest expected word
    initial begin
        forever begin
            @(negedge clock);
            if (rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rdata_unexpected: got %0h expected no beat at %0t", rdata, $time);
                end else begin
                    check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic load(input logic [12:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        cyc();
        load_en   = 1'b0;
        check("load_err_clean", 32'(load_err), 32'(0));
    endtask

    // mode 0: plain read; 1: loader strobe during burst; 2: loader strobe with req
    task automatic do_read(input logic [12:0] a, input logic [1:0] b,
                           input logic [7:0] d[4], input int mode);
        int n;
        int first;
        int nv;
        for (int k = 0; k <= int'(b); k++) exp_q.push_back(d[k]);
        req   = 1'b1;
        we    = 1'b0;
        addr  = a;
        beats = b;
        if (mode == 2) begin
            load_en   = 1'b1;
            load_addr = 13'd301;
            load_data = 8'h77;
        end
        cyc();
        req = 1'b0;
        if (mode == 2) begin
            check("load_err_with_req", 32'(load_err), 32'(1));
            load_en = 1'b0;
        end
        n = 0;
        first = 0;
        nv = 0;
        while (!ready && n < 20) begin
            cyc();
            n++;
            if (rvalid) begin
                nv++;
                if (first == 0) first = n;
            end
            if (mode == 1) begin
                if (n == 1) begin
                    load_en   = 1'b1;
                    load_addr = 13'd300;
                    load_data = 8'hEE;
                end else if (n == 2) begin
                    check("load_err_busy", 32'(load_err), 32'(1));
                    load_en = 1'b0;
                end else if (n == 3) begin
                    check("load_err_busy_end", 32'(load_err), 32'(0));
                end
            end
            if (mode == 2 && n == 1)
                check("load_err_with_req_end", 32'(load_err), 32'(0));
        end
        check("rd_ready_latency", 32'(n), 32'(int'(b) + 2));
        check("rd_first_beat", 32'(first), 32'(1));
        check("rd_beat_count", 32'(nv), 32'(int'(b) + 1));
        check("rd_rvalid_fall", 32'(rvalid), 32'(0));
    endtask

    task automatic do_write(input logic [12:0] a, input logic [1:0] b, input logic [7:0] d[4]);
        req   = 1'b1;
        we    = 1'b1;
        addr  = a;
        beats = b;
        wdata = d[0];
        cyc();
        req = 1'b0;
        for (int k = 1; k <= int'(b); k++) begin
            check("wr_busy", 32'(ready), 32'(0));
            wdata = d[k];
            cyc();
        end
        check("wr_ready_back", 32'(ready), 32'(1));
    endtask

    initial begin
        logic [7:0] d[4];
        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; beats = '0; wdata = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        cyc();
        cyc();
        check("rst_ready", 32'(ready), 32'(1));
        check("rst_rvalid", 32'(rvalid), 32'(0));
        check("rst_rdata", 32'(rdata), 32'(0));
        check("rst_load_err", 32'(load_err), 32'(0));
        reset = 1'b0;
        cyc();

        // Loader image then 4-beat read
        for (int i = 0; i < 10; i++) load(13'(1000 + i), 8'(40 + i));
        d = '{8'd40, 8'd41, 8'd42, 8'd43};
        do_read(13'd1000, 2'd3, d, 0);

        // Wrapping write burst then read back
        d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        do_write(13'd8190, 2'd3, d);
        do_read(13'd8190, 2'd3, d, 0);
        d = '{8'hA2, 8'hA3, 8'h00, 8'h00};
        do_read(13'd0, 2'd1, d, 0);

        // Single-beat write, read on the very next cycle
        d = '{8'h5A, 8'h00, 8'h00, 8'h00};
        do_write(13'd7, 2'd0, d);
        do_read(13'd7, 2'd0, d, 0);

        // Loader strobe during a busy burst is dropped
        load(13'd300, 8'h11);
        load(13'd301, 8'h22);
        d = '{8'd40, 8'd41, 8'd42, 8'd43};
        do_read(13'd1000, 2'd3, d, 1);
        d = '{8'h11, 8'h00, 8'h00, 8'h00};
        do_read(13'd300, 2'd0, d, 0);

        // Loader strobe together with req is dropped, req proceeds
        d = '{8'd40, 8'h00, 8'h00, 8'h00};
        do_read(13'd1000, 2'd0, d, 2);
        d = '{8'h22, 8'h00, 8'h00, 8'h00};
        do_read(13'd301, 2'd0, d, 0);

        // Reset after beat 1 of a 4-beat write
        for (int i = 0; i < 4; i++) load(13'(20 + i), 8'(8'h30 + i));
        req = 1'b1; we = 1'b1; addr = 13'd20; beats = 2'd3; wdata = 8'hC0;
        cyc();
        req = 1'b0; wdata = 8'hC1;
        cyc();
        wdata = 8'hC2;
        reset = 1'b1;
        #1;
        check("midburst_rst_ready", 32'(ready), 32'(1));
        check("midburst_rst_rvalid", 32'(rvalid), 32'(0));
        cyc();
        wdata = 8'hC3;
        cyc();
        reset = 1'b0;
        cyc();
        d = '{8'hC0, 8'hC1, 8'h32, 8'h33};
        do_read(13'd20, 2'd3, d, 0);

        cyc();
        cyc();
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
